// File: rtl/miriscv_dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: master IDs, bus width and request bundle.
package miriscv_pkg;

    localparam int BUS_W     = 32;
    localparam int N_MASTERS = 2;

    typedef enum logic {
        M_CORE = 1'b0,
        M_DMA  = 1'b1
    } master_id_e;

    typedef struct packed {
        logic             req;
        logic             we;
        logic [3:0]       be;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] wdata;
    } bus_req_t;

    // Unsigned compare; the RAM window always starts at byte 0.
    function automatic logic addr_in_range(input logic [BUS_W-1:0] addr,
                                           input logic [BUS_W-1:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/miriscv_dmem_arbiter_if.sv
// One master's data-memory bus: request fields toward the arbiter, response fields back.
interface miriscv_dmem_arbiter_if;
    import miriscv_pkg::*;

    logic             req;
    logic             we;
    logic [3:0]       be;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [BUS_W-1:0] rdata;
    logic             err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/miriscv_dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a hold counter that lets a lone master keep priority
// for up to MAX_HOLD consecutive grants.
module miriscv_rr_arbiter2
    import miriscv_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_MASTERS-1:0] req_i,
    output logic [N_MASTERS-1:0] gnt_o
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    master_id_e    rr_q, rr_d;
    master_id_e    last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    master_id_e    win;
    logic          any_req;
    logic          other_req;

    always_comb begin
        any_req = |req_i;
        win     = rr_q;
        if (req_i[0] && !req_i[1]) begin
            win = M_CORE;
        end else if (req_i[1] && !req_i[0]) begin
            win = M_DMA;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_gnt
            assign gnt_o[gi] = any_req && !rst_i && (logic'(win) == 1'(gi));
        end
    endgenerate

    always_comb begin
        rr_d      = rr_q;
        last_d    = last_q;
        hold_d    = hold_q;
        other_req = (win == M_CORE) ? req_i[1] : req_i[0];
        if (any_req) begin
            last_d = win;
            if (win != last_q) begin
                hold_d = HW'(1);
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end
            // Keep priority on the current master only while it is alone and under quota.
            if ((hold_d < HOLD_MAX) && !other_req) begin
                rr_d = win;
            end else begin
                rr_d = master_id_e'(~win);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= M_CORE;
            last_q <= M_CORE;
            hold_q <= '0;
        end else begin
            rr_q   <= rr_d;
            last_q <= last_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/miriscv_dmem_arbiter.sv
// Shares one data RAM between the core (m0) and DMA/debug (m1): grants in the request cycle,
// decodes the RAM window and routes the single-cycle-latency response back to the winner.
module miriscv_dmem_arbiter
    import miriscv_pkg::*;
#(
    parameter int RAM_SIZE = 256,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             m0_req_i,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_be_i,
    input  logic [BUS_W-1:0] m0_addr_i,
    input  logic [BUS_W-1:0] m0_wdata_i,
    output logic             m0_gnt_o,
    output logic             m0_rvalid_o,
    output logic [BUS_W-1:0] m0_rdata_o,
    output logic             m0_err_o,

    input  logic             m1_req_i,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_be_i,
    input  logic [BUS_W-1:0] m1_addr_i,
    input  logic [BUS_W-1:0] m1_wdata_i,
    output logic             m1_gnt_o,
    output logic             m1_rvalid_o,
    output logic [BUS_W-1:0] m1_rdata_o,
    output logic             m1_err_o,

    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic [BUS_W-1:0] ram_addr_o,
    output logic [BUS_W-1:0] ram_wdata_o,
    input  logic [BUS_W-1:0] ram_rdata_i
);

    localparam logic [BUS_W-1:0] RAM_LIMIT = BUS_W'(RAM_SIZE);

    bus_req_t             mreq [N_MASTERS];
    logic [N_MASTERS-1:0] req_vec;
    logic [N_MASTERS-1:0] gnt_vec;
    logic [N_MASTERS-1:0] in_range_vec;
    logic [N_MASTERS-1:0] rvalid_vec;
    logic [N_MASTERS-1:0] err_vec;
    logic [BUS_W-1:0]     rdata_arr [N_MASTERS];

    master_id_e           sel_id;
    bus_req_t             sel;
    logic                 sel_in_range;
    logic                 any_gnt;

    logic                 resp_valid_q, resp_valid_d;
    master_id_e           resp_id_q, resp_id_d;
    logic                 resp_err_q, resp_err_d;
    logic                 resp_we_q, resp_we_d;
    logic                 resp_active;
    logic [BUS_W-1:0]     resp_rdata;

    assign mreq[0] = {m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i};
    assign mreq[1] = {m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i};

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
            assign req_vec[gi]      = mreq[gi].req;
            assign in_range_vec[gi] = addr_in_range(mreq[gi].addr, RAM_LIMIT);
            assign rvalid_vec[gi]   = resp_active && (logic'(resp_id_q) == 1'(gi));
            assign err_vec[gi]      = rvalid_vec[gi] && resp_err_q;
            assign rdata_arr[gi]    = rvalid_vec[gi] ? resp_rdata : '0;
        end
    endgenerate

    miriscv_rr_arbiter2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_rr_arbiter2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_vec),
        .gnt_o (gnt_vec)
    );

    always_comb begin
        any_gnt      = |gnt_vec;
        sel_id       = gnt_vec[1] ? M_DMA : M_CORE;
        sel          = mreq[sel_id];
        sel_in_range = in_range_vec[sel_id];

        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        // Out-of-range grants never reach the RAM; they are answered with err next cycle.
        if (any_gnt && sel_in_range) begin
            ram_req_o   = 1'b1;
            ram_we_o    = sel.we;
            ram_be_o    = sel.be;
            ram_addr_o  = sel.addr;
            ram_wdata_o = sel.wdata;
        end

        resp_valid_d = any_gnt;
        resp_id_d    = sel_id;
        resp_err_d   = any_gnt && !sel_in_range;
        resp_we_d    = any_gnt && sel.we;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= M_CORE;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            resp_we_q    <= resp_we_d;
        end
    end

    // Reset is synchronous, so a stale response would otherwise leak out during the reset cycle.
    assign resp_active = resp_valid_q && !rst_i;
    assign resp_rdata  = (resp_active && !resp_we_q && !resp_err_q) ? ram_rdata_i : '0;

    assign m0_gnt_o    = gnt_vec[0];
    assign m0_rvalid_o = rvalid_vec[0];
    assign m0_err_o    = err_vec[0];
    assign m0_rdata_o  = rdata_arr[0];

    assign m1_gnt_o    = gnt_vec[1];
    assign m1_rvalid_o = rvalid_vec[1];
    assign m1_err_o    = err_vec[1];
    assign m1_rdata_o  = rdata_arr[1];

endmodule
